// File: rtl/jt51_pkg.sv
// jt51_pkg: shared widths, algorithm thresholds and carrier decode for the JT51 output mixer
package jt51_pkg;
    localparam int OP_W    = 14;
    localparam int ACC_W   = 19;
    localparam int OUT_W   = 16;
    localparam int NOISE_W = 12;
    localparam int MANT_W  = 10;
    localparam int EXP_MAX = 6;

    localparam logic [2:0] CON_C1_MIN  = 3'd4;
    localparam logic [2:0] CON_M2_MIN  = 3'd5;
    localparam logic [2:0] CON_M1_ONLY = 3'd7;

    // Carrier decode: one add per slot however many role strobes are set
    function automatic logic is_carrier(input logic m1, input logic m2, input logic c1,
                                        input logic c2, input logic [2:0] con);
        return c2 | (c1 & (con >= CON_C1_MIN)) | (m2 & (con >= CON_M2_MIN)) | (m1 & (con == CON_M1_ONLY));
    endfunction
endpackage

// File: rtl/jt51_acc_mix_if.sv
// jt51_acc_mix_if: operator-slot stream into the mixer and the four mixed outputs
interface jt51_acc_mix_if;
    import jt51_pkg::*;
    logic                      cen;
    logic                      m1_enters;
    logic                      m2_enters;
    logic                      c1_enters;
    logic                      c2_enters;
    logic                      op31_acc;
    logic [1:0]                rl_I;
    logic [2:0]                con_I;
    logic signed [OP_W-1:0]    op_out;
    logic                      ne;
    logic signed [NOISE_W-1:0] noise_mix;
    logic signed [OUT_W-1:0]   left;
    logic signed [OUT_W-1:0]   right;
    logic signed [OUT_W-1:0]   xleft;
    logic signed [OUT_W-1:0]   xright;

    modport master (
        output cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
               rl_I, con_I, op_out, ne, noise_mix,
        input  left, right, xleft, xright
    );
    modport slave (
        input  cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
               rl_I, con_I, op_out, ne, noise_mix,
        output left, right, xleft, xright
    );
endinterface

// File: rtl/jt51_acc_fp.sv
// jt51_acc_fp: clamp a frame total to 16 bits and requantize it to a 10-bit mantissa / 3-bit exponent float
module jt51_acc_fp
    import jt51_pkg::*;
(
    input  logic signed [ACC_W-1:0] total,
    output logic signed [OUT_W-1:0] sat,
    output logic signed [OUT_W-1:0] fp
);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 <<< (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0] MANT_HI = OUT_W'((1 <<< (MANT_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] MANT_LO = OUT_W'(-(1 <<< (MANT_W - 1)));

    logic signed [OUT_W-1:0] mant;

    // Clamp, then keep the smallest exponent whose shifted value fits the mantissa
    always_comb begin
        sat  = total > SAT_HI ? SAT_HI[OUT_W-1:0] : total < SAT_LO ? SAT_LO[OUT_W-1:0] : total[OUT_W-1:0];
        fp   = (sat >>> EXP_MAX) <<< EXP_MAX;
        mant = '0;
        for (int i = EXP_MAX - 1; i >= 0; i--) begin
            mant = sat >>> i;
            if (mant >= MANT_LO && mant <= MANT_HI) fp = mant <<< i;
        end
    end
endmodule

// File: rtl/jt51_acc_mix.sv
// jt51_acc_mix: per-frame left/right carrier accumulator with saturated and float-requantized outputs
module jt51_acc_mix
    import jt51_pkg::*;
(
    input logic           clk,
    input logic           rst,
    jt51_acc_mix_if.slave bus
);
    logic                    add;
    logic                    frame_end;
    logic signed [ACC_W-1:0] sample;
    logic signed [ACC_W-1:0] tot_l;
    logic signed [ACC_W-1:0] tot_r;
    logic signed [ACC_W-1:0] acc_l_d, acc_l_q;
    logic signed [ACC_W-1:0] acc_r_d, acc_r_q;
    logic signed [OUT_W-1:0] sat_l, sat_r, fp_l, fp_r;
    logic signed [OUT_W-1:0] xleft_d, xleft_q, xright_d, xright_q;
    logic signed [OUT_W-1:0] left_d, left_q, right_d, right_q;

    // Decode the carrier slot, choose op or noise sample, and form totals including this slot
    always_comb begin
        add       = is_carrier(bus.m1_enters, bus.m2_enters, bus.c1_enters, bus.c2_enters, bus.con_I);
        frame_end = bus.cen && bus.op31_acc;
        sample    = (bus.ne && bus.op31_acc)
                  ? {{(ACC_W - NOISE_W - 2){bus.noise_mix[NOISE_W-1]}}, bus.noise_mix, 2'b00}
                  : {{(ACC_W - OP_W){bus.op_out[OP_W-1]}}, bus.op_out};
        tot_l     = acc_l_q + ((add && bus.rl_I[0]) ? sample : '0);
        tot_r     = acc_r_q + ((add && bus.rl_I[1]) ? sample : '0);
        acc_l_d   = !bus.cen ? acc_l_q : bus.op31_acc ? '0 : tot_l;
        acc_r_d   = !bus.cen ? acc_r_q : bus.op31_acc ? '0 : tot_r;
        xleft_d   = frame_end ? sat_l : xleft_q;
        xright_d  = frame_end ? sat_r : xright_q;
        left_d    = frame_end ? fp_l : left_q;
        right_d   = frame_end ? fp_r : right_q;
    end

    jt51_acc_fp u_fp_l (.total(tot_l), .sat(sat_l), .fp(fp_l));
    jt51_acc_fp u_fp_r (.total(tot_r), .sat(sat_r), .fp(fp_r));

    // Accumulators and frame outputs; outputs only move on the last slot of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            xleft_q  <= '0;
            xright_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            xleft_q  <= xleft_d;
            xright_q <= xright_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign bus.xleft  = xleft_q;
    assign bus.xright = xright_q;
    assign bus.left   = left_q;
    assign bus.right  = right_q;
endmodule

// File: tb/tb_jt51_acc_mix.sv
// tb_jt51_acc_mix: directed and randomized checks of the JT51 output mixer against a frame-sum model
module tb_jt51_acc_mix;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   m_acc_l, m_acc_r;
    int   e_xl, e_xr, e_l, e_r;
    int   got[4];
    int   want[4];
    string nm[4] = '{"xleft", "xright", "left", "right"};

    jt51_acc_mix_if bus();

    jt51_acc_mix dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which operator roles {c2,c1,m2,m1} are carriers, per algorithm table
    function automatic logic [3:0] carriers(input int con);
        if (con < 4) return 4'b1000;
        if (con == 4) return 4'b1100;
        if (con < 7) return 4'b1110;
        return 4'b1111;
    endfunction

    function automatic int sat16(input int x);
        return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
    endfunction

    function automatic int rq(input int x);
        for (int e = 0; e < 6; e++)
            if (x >= -512 * (1 << e) && x < 512 * (1 << e)) return (x >>> e) * (1 << e);
        return (x >>> 6) * 64;
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic sample_outs();
        got  = '{sx(bus.xleft), sx(bus.xright), sx(bus.left), sx(bus.right)};
        want = '{e_xl, e_xr, e_l, e_r};
    endtask

    task automatic model_clear();
        m_acc_l = 0; m_acc_r = 0;
        e_xl = 0; e_xr = 0; e_l = 0; e_r = 0;
    endtask

    task automatic slot(input logic c, input logic [3:0] st, input logic last, input logic [1:0] rl,
                        input logic [2:0] con, input int op, input logic n, input int nmx);
        int s, tl, tr;
        logic a;
        bus.cen = c;
        bus.m1_enters = st[0]; bus.m2_enters = st[1]; bus.c1_enters = st[2]; bus.c2_enters = st[3];
        bus.op31_acc = last; bus.rl_I = rl; bus.con_I = con;
        bus.op_out = 14'(op); bus.ne = n; bus.noise_mix = 12'(nmx);
        @(posedge clk);
        #1;
        if (c) begin
            s  = (n && last) ? nmx * 4 : op;
            a  = |(st & carriers(int'(con)));
            tl = m_acc_l + ((a && rl[0]) ? s : 0);
            tr = m_acc_r + ((a && rl[1]) ? s : 0);
            if (last) begin
                e_xl = sat16(tl); e_xr = sat16(tr);
                e_l = rq(e_xl); e_r = rq(e_xr);
                m_acc_l = 0; m_acc_r = 0;
            end else begin
                m_acc_l = tl; m_acc_r = tr;
            end
        end
    endtask

    task automatic frame(input logic [2:0] con, input logic [1:0] rl, input int op);
        for (int i = 0; i < 32; i++) slot(1'b1, 4'(1 << (i % 4)), i == 31, rl, con, op, 1'b0, 0);
    endtask

    task automatic test_reset();
        bus.cen = 0; bus.m1_enters = 0; bus.m2_enters = 0; bus.c1_enters = 0; bus.c2_enters = 0;
        bus.op31_acc = 0; bus.rl_I = 0; bus.con_I = 0; bus.op_out = 0; bus.ne = 0; bus.noise_mix = 0;
        rst = 1'b1;
        model_clear();
        #22;
        sample_outs();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 0) begin errors++; $display("FAIL reset %s got %0d want 0", nm[k], got[k]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_all_carriers();
        frame(3'd7, 2'b11, 100);
        sample_outs();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 3200) begin errors++; $display("FAIL all_carriers %s got %0d want 3200", nm[k], got[k]); end
        end
    endtask

    task automatic test_saturation();
        frame(3'd7, 2'b11, 8191);
        checks++;
        if (sx(bus.xleft) !== 32767) begin errors++; $display("FAIL sat_pos xleft got %0d want 32767", sx(bus.xleft)); end
        checks++;
        if (sx(bus.left) !== 32704) begin errors++; $display("FAIL sat_pos left got %0d want 32704", sx(bus.left)); end
        frame(3'd7, 2'b11, -8192);
        checks++;
        if (sx(bus.xright) !== -32768) begin errors++; $display("FAIL sat_neg xright got %0d want -32768", sx(bus.xright)); end
        checks++;
        if (sx(bus.left) !== -32768) begin errors++; $display("FAIL sat_neg left got %0d want -32768", sx(bus.left)); end
    endtask

    task automatic test_masking();
        frame(3'd0, 2'b01, 50);
        checks++;
        if (sx(bus.xleft) !== 400) begin errors++; $display("FAIL mask xleft got %0d want 400", sx(bus.xleft)); end
        checks++;
        if (sx(bus.xright) !== 0) begin errors++; $display("FAIL mask xright got %0d want 0", sx(bus.xright)); end
        checks++;
        if (sx(bus.left) !== 400) begin errors++; $display("FAIL mask left got %0d want 400", sx(bus.left)); end
    endtask

    task automatic test_noise();
        for (int i = 0; i < 32; i++)
            slot(1'b1, 4'(1 << (i % 4)), i == 31, 2'b11, 3'd7, i == 31 ? 1000 : 0, 1'b1, -4);
        checks++;
        if (sx(bus.xleft) !== -16) begin errors++; $display("FAIL noise xleft got %0d want -16", sx(bus.xleft)); end
        checks++;
        if (sx(bus.right) !== -16) begin errors++; $display("FAIL noise right got %0d want -16", sx(bus.right)); end
    endtask

    task automatic test_cen_hold();
        for (int i = 0; i < 10; i++) slot(1'b1, 4'(1 << (i % 4)), 1'b0, 2'b11, 3'd7, 100, 1'b0, 0);
        for (int i = 0; i < 5; i++) slot(1'b0, 4'b1111, i == 2, 2'b11, 3'd7, 5000, 1'b0, 0);
        checks++;
        if (sx(bus.xleft) !== -16) begin errors++; $display("FAIL cen_hold xleft got %0d want -16", sx(bus.xleft)); end
        for (int i = 10; i < 32; i++) slot(1'b1, 4'(1 << (i % 4)), i == 31, 2'b11, 3'd7, 100, 1'b0, 0);
        checks++;
        if (sx(bus.xleft) !== 3200) begin errors++; $display("FAIL cen_frame xleft got %0d want 3200", sx(bus.xleft)); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) slot(1'b1, 4'b1111, 1'b0, 2'b11, 3'd7, 3000, 1'b0, 0);
        rst = 1'b1;
        #2;
        sample_outs();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 0) begin errors++; $display("FAIL reset_mid %s got %0d want 0", nm[k], got[k]); end
        end
        rst = 1'b0;
        model_clear();
        frame(3'd7, 2'b11, 100);
        checks++;
        if (sx(bus.xright) !== 3200) begin errors++; $display("FAIL post_reset xright got %0d want 3200", sx(bus.xright)); end
    endtask

    task automatic test_requant();
        int tv[4] = '{511, 512, 1023, 1025};
        int lv[4] = '{511, 512, 1022, 1024};
        for (int k = 0; k < 4; k++) begin
            slot(1'b1, 4'b1000, 1'b1, 2'b11, 3'd0, tv[k], 1'b0, 0);
            checks++;
            if (sx(bus.xleft) !== tv[k]) begin errors++; $display("FAIL requant xleft got %0d want %0d", sx(bus.xleft), tv[k]); end
            checks++;
            if (sx(bus.left) !== lv[k]) begin errors++; $display("FAIL requant left got %0d want %0d", sx(bus.left), lv[k]); end
        end
    endtask

    task automatic test_random();
        int len;
        logic n;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 32);
            n = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if (i == len - 1)
                    slot(1'b1, 4'($urandom_range(0, 15)), 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                         int'($urandom_range(0, 16383)) - 8192, n, int'($urandom_range(0, 4095)) - 2048);
                else
                    slot(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) == 0),
                         2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                         int'($urandom_range(0, 16383)) - 8192, n, int'($urandom_range(0, 4095)) - 2048);
                if (bus.cen && bus.op31_acc && i != len - 1) begin
                    sample_outs();
                end
                sample_outs();
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (got[k] !== want[k]) begin
                        errors++;
                        $display("FAIL random f%0d s%0d %s got %0d want %0d", f, i, nm[k], got[k], want[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_carriers();
        test_saturation();
        test_masking();
        test_noise();
        test_cen_hold();
        test_reset_mid();
        test_requant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
